fft_frame_sequencer: RTL and testbench

- Control FSM that sequences one 16-point radix-2 FFT frame through the input buffer, the twiddle LUT and the 8-lane butterfly array.
- Streams 16 complex words into the buffer, then steps the stage index through all log2(16) stages with a write-back strobe per stage.
- Finally streams the 16 results out through the buffer read port.
- Sits between the external stream interfaces and the FFT top-level datapath; owns every buffer and LUT control signal.

---
 rtl/fft_frame_sequencer.sv | 144 ++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
// Control FSM for one radix-2 FFT frame: load samples, step through the butterfly stages, unload results.
// Define FFT_BITREV_LOAD_EN to store loaded samples at bit-reversed buffer addresses.
module fft_frame_sequencer #(
  parameter int NPOINT     = 16,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 32,
  parameter int NUM_STAGES = 4,
  parameter int STAGE_W    = 2,
  parameter int BF_LAT     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               write_enable,
  output logic [ADDR_W-1:0]  write_address,
  output logic [DATA_W-1:0]  data_in,
  output logic               read_enable,
  output logic [ADDR_W-1:0]  read_address,
  input  logic [DATA_W-1:0]  data_out,
  output logic [STAGE_W-1:0] stage,
  output logic               write_back,
  output logic               busy,
  output logic               done
);
  // state   | meaning
  // LOAD    | accept NPOINT input words into the buffer
  // COMPUTE | wait BF_LAT cycles for the butterfly pipeline on the current stage
  // WB      | one-cycle commit of butterfly outputs, then next stage or unload
  // UNLOAD  | stream NPOINT results out of the buffer in natural order
  typedef enum logic [1:0] {LOAD, COMPUTE, WB, UNLOAD} state_t;

  localparam int LAT_W = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam logic [ADDR_W-1:0]  CNT_LAST   = ADDR_W'(NPOINT - 1);
  localparam logic [LAT_W-1:0]   LAT_LAST   = LAT_W'(BF_LAT - 1);
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_STAGES - 1);

  state_t             state, state_n;
  logic [ADDR_W-1:0]  cnt, cnt_n;
  logic [LAT_W-1:0]   lat, lat_n;
  logic [STAGE_W-1:0] stage_q, stage_n;
  logic               done_q, done_n;
  logic [ADDR_W-1:0]  load_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      cnt     <= '0;
      lat     <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      lat     <= lat_n;
      stage_q <= stage_n;
      done_q  <= done_n;
    end
  end

`ifdef FFT_BITREV_LOAD_EN
  // Decimation-in-time stages expect the frame in bit-reversed order.
  always_comb begin
    load_addr = '0;
    for (int i = 0; i < ADDR_W; i++) load_addr[i] = cnt[ADDR_W-1-i];
  end
`else
  assign load_addr = cnt;
`endif

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    lat_n        = lat;
    stage_n      = stage_q;
    done_n       = 1'b0;
    in_ready     = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    out_valid    = 1'b0;
    write_back   = 1'b0;
    busy         = 1'b0;
    unique case (state)
      LOAD: begin
        in_ready     = 1'b1;
        write_enable = in_valid;
        if (in_valid) begin
          if (cnt == CNT_LAST) begin
            cnt_n   = '0;
            lat_n   = '0;
            stage_n = '0;
            state_n = COMPUTE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      COMPUTE: begin
        busy = 1'b1;
        if (lat == LAT_LAST) state_n = WB;
        else                 lat_n   = lat + 1'b1;
      end
      WB: begin
        busy       = 1'b1;
        write_back = 1'b1;
        if (stage_q == STAGE_LAST) begin
          stage_n = '0;
          cnt_n   = '0;
          state_n = UNLOAD;
        end else begin
          stage_n = stage_q + 1'b1;
          lat_n   = '0;
          state_n = COMPUTE;
        end
      end
      UNLOAD: begin
        out_valid   = 1'b1;
        read_enable = 1'b1;
        if (out_ready) begin
          if (cnt == CNT_LAST) begin
            cnt_n   = '0;
            done_n  = 1'b1;
            state_n = LOAD;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: state_n = LOAD;
    endcase
  end

  assign write_address = load_addr;
  assign data_in       = in_data;
  assign read_address  = cnt;
  assign out_data      = data_out;
  assign stage         = stage_q;
  assign done          = done_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer: frame-level reference model plus directed literal checks.
// Honours FFT_BITREV_LOAD_EN the same way as the design.
module tb_fft_frame_sequencer;
  localparam int NPOINT     = 16;
  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 32;
  localparam int NUM_STAGES = 4;
  localparam int STAGE_W    = 2;
  localparam int BF_LAT     = 2;
  localparam int CCYC       = NUM_STAGES * (BF_LAT + 1);

  logic               clk, rst;
  logic               in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0]  in_data, out_data, data_in, data_out;
  logic               write_enable, read_enable, write_back, busy, done;
  logic [ADDR_W-1:0]  write_address, read_address;
  logic [STAGE_W-1:0] stage;

  fft_frame_sequencer #(
    .NPOINT(NPOINT), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .NUM_STAGES(NUM_STAGES), .STAGE_W(STAGE_W), .BF_LAT(BF_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .write_enable(write_enable), .write_address(write_address), .data_in(data_in),
    .read_enable(read_enable), .read_address(read_address), .data_out(data_out),
    .stage(stage), .write_back(write_back), .busy(busy), .done(done)
  );

  // Buffer stand-in: synchronous write, combinational read.
  logic [DATA_W-1:0] buf_mem [NPOINT];
  always @(posedge clk) if (write_enable) buf_mem[write_address] <= data_in;
  assign data_out = buf_mem[read_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FFT_BITREV_LOAD_EN
  int lit_addr [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`else
  int lit_addr [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif
  int lit_wb    [4]  = '{3, 6, 9, 12};
  int lit_stage [12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
  int lit_pat   [4]  = '{1, 0, 0, 1};

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int amap(input int i);
`ifdef FFT_BITREV_LOAD_EN
    int r = 0;
    for (int b = 0; b < ADDR_W; b++) if (i[b]) r |= 1 << (ADDR_W - 1 - b);
    return r;
`else
    return i;
`endif
  endfunction

  // Frame model: counts of words loaded, compute cycles elapsed, words unloaded.
  int          m_loaded = 0, m_ccyc = 0, m_unl = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_samp [NPOINT];

  always @(posedge clk) begin
    if (rst) begin
      m_loaded = 0; m_ccyc = 0; m_unl = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_loaded < NPOINT) begin
        if (in_valid) begin
          m_samp[m_loaded] = in_data;
          m_loaded++;
        end
      end else if (m_ccyc < CCYC) begin
        m_ccyc++;
      end else if (out_ready) begin
        m_unl++;
        if (m_unl == NPOINT) begin
          m_loaded = 0; m_ccyc = 0; m_unl = 0; m_done = 1'b1;
        end
      end
    end
  end

  logic e_ld, e_cp, e_ul;
  always @(negedge clk) if (chk_en) begin
    e_ld = (m_loaded < NPOINT);
    e_cp = !e_ld && (m_ccyc < CCYC);
    e_ul = !e_ld && !e_cp;
    chk("m_in_ready", 32'(in_ready), 32'(e_ld));
    chk("m_busy", 32'(busy), 32'(e_cp));
    chk("m_write_enable", 32'(write_enable), 32'(e_ld && in_valid));
    if (e_ld) chk("m_write_address", 32'(write_address), 32'(amap(m_loaded)));
    if (e_ld && in_valid) chk("m_data_in", data_in, in_data);
    chk("m_stage", 32'(stage), e_cp ? 32'(m_ccyc / (BF_LAT + 1)) : 32'd0);
    chk("m_write_back", 32'(write_back), 32'(e_cp && (m_ccyc % (BF_LAT + 1)) == BF_LAT));
    chk("m_out_valid", 32'(out_valid), 32'(e_ul));
    chk("m_read_enable", 32'(read_enable), 32'(e_ul));
    if (e_ul) begin
      chk("m_read_address", 32'(read_address), 32'(m_unl));
      chk("m_out_data", out_data, m_samp[amap(m_unl)]);
    end
    chk("m_done", 32'(done), 32'(m_done));
    chk("m_we_wb_exclusive", 32'(write_enable && write_back), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int c, n, k, p, wbn, dn, wen;
  int wb_cyc [8];
  int st_seq [40];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_stage", 32'(stage), 32'd0);
    chk("rst_write_back", 32'(write_back), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    tick();

    // Frame 1: back-to-back load, then stage timing, then unload with out_ready toggling.
    for (int i = 0; i < NPOINT; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      @(negedge clk);
      chk("f1_write_enable", 32'(write_enable), 32'd1);
      chk("f1_write_address", 32'(write_address), 32'(lit_addr[i]));
      tick();
    end
    in_data = 32'hDEAD_BEEF;
    c = 1; wbn = 0;
    while (c < 40) begin
      @(negedge clk);
      if (c == 1) begin
        chk("f1_in_ready_after_last", 32'(in_ready), 32'd0);
        chk("f1_ignored_in_valid", 32'(write_enable), 32'd0);
      end
      if (out_valid) break;
      if (write_back && wbn < 8) begin wb_cyc[wbn] = c; wbn++; end
      st_seq[c-1] = 32'(stage);
      tick();
      c++;
      if (c == 2) in_valid = 1'b0;
    end
    chk("f1_first_out_cycle", 32'(c), 32'd13);
    chk("f1_wb_count", 32'(wbn), 32'd4);
    for (int j = 0; j < 4; j++) chk("f1_wb_cycle", 32'(wb_cyc[j]), 32'(lit_wb[j]));
    for (int j = 0; j < 12; j++) chk("f1_stage_seq", 32'(st_seq[j]), 32'(lit_stage[j]));
    tick();
    n = 0; dn = 0;
    for (k = 0; k < 32; k++) begin
      out_ready = (k % 2 == 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (n < NPOINT) begin
          chk("f1_read_address", 32'(read_address), 32'(n));
          chk("f1_out_data", out_data, 32'(lit_addr[n]));
        end
        n++;
      end
      if (done) dn++;
      tick();
    end
    out_ready = 1'b0;
    @(negedge clk);
    chk("f1_transfers", 32'(n), 32'd16);
    chk("f1_done_pulses", 32'(dn), 32'd1);
    chk("f1_in_ready_after_done", 32'(in_ready), 32'd1);
    chk("f1_done_cleared", 32'(done), 32'd0);
    tick();

    // Frame 2: gapped load, then reset mid-compute at stage 2.
    n = 0; p = 0; wen = 0;
    while (n < NPOINT && p < 80) begin
      in_valid = lit_pat[p % 4][0]; in_data = 32'hA500_0000 | 32'(n);
      @(negedge clk);
      if (write_enable) begin
        wen++;
        if (n < NPOINT) chk("f2_write_address", 32'(write_address), 32'(lit_addr[n]));
        n++;
      end else if (n < NPOINT) begin
        chk("f2_gap_address_held", 32'(write_address), 32'(lit_addr[n]));
      end
      tick();
      p++;
    end
    in_valid = 1'b0;
    chk("f2_we_pulses", 32'(wen), 32'd16);
    chk("f2_load_cycles", 32'(p), 32'd32);
    c = 0;
    while (c < 40) begin
      @(negedge clk);
      if (stage == 2'd2 && busy) break;
      tick();
      c++;
    end
    chk("f2_reached_stage2", 32'(c < 40), 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_stage", 32'(stage), 32'd0);
    chk("abort_write_back", 32'(write_back), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    tick();

    // Frame 3: full frame after abort, out_ready held high throughout.
    out_ready = 1'b1;
    for (int i = 0; i < NPOINT; i++) begin
      in_valid = 1'b1; in_data = 32'h1234_0000 + 32'(i) * 32'h0101;
      tick();
    end
    in_valid = 1'b0;
    wbn = 0; dn = 0; c = 0;
    while (dn == 0 && c < 200) begin
      @(negedge clk);
      if (write_back) wbn++;
      if (done) dn++;
      tick();
      c++;
    end
    chk("f3_wb_count", 32'(wbn), 32'd4);
    chk("f3_done_seen", 32'(dn), 32'd1);
    chk("f3_cycles_to_done", 32'(c), 32'd29);
    out_ready = 1'b0;
    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
